// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store port: RV32I size codes, FSM states and defaults.
// The optional misalignment trap (LSU_MISALIGN_TRAP_EN) uses the misaligned() helper below.
package lsu_pkg;

  localparam int DMEM_SIZE_DEFAULT = 4096;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Stores only exist in signed-size form; unsigned codes are load-only.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      F3_H, F3_HU: bad = off[0];
      F3_W:        bad = (off != 2'b00);
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] word,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and halfword lanes of the memory word.
  always_comb begin
    byte_s = 8'd0;
    case (byte_off)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (byte_off[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
  end

  // Extend the selected lane to a full register value.
  always_comb begin
    load_data = 32'd0;
    case (funct3)
      F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
      F3_H:    load_data = {{16{half_s[15]}}, half_s};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'd0, byte_s};
      F3_HU:   load_data = {16'd0, half_s};
      default: load_data = 32'd0;
    endcase
  end

  // Replace the addressed byte/half of the read word with store data.
  always_comb begin
    merge_data = word;
    case (funct3)
      F3_B: begin
        case (byte_off)
          2'd0:    merge_data[7:0]   = store_data[7:0];
          2'd1:    merge_data[15:8]  = store_data[7:0];
          2'd2:    merge_data[23:16] = store_data[7:0];
          2'd3:    merge_data[31:24] = store_data[7:0];
          default: merge_data = word;
        endcase
      end
      F3_H: begin
        if (byte_off[1]) begin
          merge_data[31:16] = store_data;
        end else begin
          merge_data[15:0] = store_data;
        end
      end
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// Single-outstanding RV32I load/store port to a word-wide data memory, byte stores done as RMW.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module lsu_port
  import lsu_pkg::*;
#(
  parameter int DMEM_SIZE = DMEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_r;
  logic        we_r;
  logic [2:0]  funct3_r;
  logic [1:0]  off_r;
  logic [15:0] sdata_r;

  logic        mem_read_r;
  logic        mem_write_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_err_r;

  logic        req_err_s;
  logic        req_sw_s;
  logic [31:0] load_data_s;
  logic [31:0] merge_data_s;

  lsu_align u_align (
    .funct3     (funct3_r),
    .byte_off   (off_r),
    .word       (mem_rdata),
    .store_data (sdata_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // Classify the request presented in IDLE.
  always_comb begin
    req_sw_s  = req_we && (req_funct3 == F3_W);
    req_err_s = 1'b0;
    if (!funct3_legal(req_we, req_funct3)) begin
      req_err_s = 1'b1;
    end else if (req_addr >= 32'(DMEM_SIZE)) begin
      req_err_s = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    end else if (misaligned(req_funct3, req_addr[1:0])) begin
      req_err_s = 1'b1;
`endif
    end else begin
      req_err_s = 1'b0;
    end
  end

  // Main FSM with registered memory strobes and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      we_r        <= 1'b0;
      funct3_r    <= 3'd0;
      off_r       <= 2'd0;
      sdata_r     <= 16'd0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            we_r     <= req_we;
            funct3_r <= req_funct3;
            off_r    <= req_addr[1:0];
            sdata_r  <= req_wdata[15:0];
            if (req_err_s) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 32'd0;
            end else begin
              state_r     <= ST_ACCESS;
              mem_addr_r  <= {req_addr[31:2], 2'b00};
              mem_read_r  <= ~req_sw_s;
              mem_write_r <= req_sw_s;
              mem_wdata_r <= req_sw_s ? req_wdata : 32'd0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          mem_read_r <= 1'b0;
          if (!we_r) begin
            state_r     <= ST_RESP;
            mem_addr_r  <= 32'd0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= load_data_s;
            rsp_err_r   <= 1'b0;
          end else if (funct3_r == F3_W) begin
            state_r     <= ST_RESP;
            mem_write_r <= 1'b0;
            mem_wdata_r <= 32'd0;
            mem_addr_r  <= 32'd0;
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
          end else begin
            // Sub-word store: write back the merged word next cycle at the same address.
            state_r     <= ST_MERGE;
            mem_write_r <= 1'b1;
            mem_wdata_r <= merge_data_s;
          end
        end
        ST_MERGE: begin
          state_r     <= ST_RESP;
          mem_write_r <= 1'b0;
          mem_wdata_r <= 32'd0;
          mem_addr_r  <= 32'd0;
          rsp_valid_r <= 1'b1;
          rsp_rdata_r <= 32'd0;
          rsp_err_r   <= 1'b0;
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'd0;
          rsp_err_r   <= 1'b0;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          mem_addr_r  <= 32'd0;
          mem_wdata_r <= 32'd0;
          rsp_valid_r <= 1'b0;
          rsp_rdata_r <= 32'd0;
          rsp_err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Ready is gated by rst_n so it reads 0 during reset and 1 right after release.
  assign req_ready = rst_n & (state_r == ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;
  assign mem_read  = mem_read_r;
  assign mem_write = mem_write_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: doc/lsu_port.md
LSU_PORT -- requirements
Module: lsu_port

Interface
REQ-001 SHALL have parameter DMEM_SIZE, default 4096, meaning data memory size in bytes; addresses at or above it are out of range.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1 bit: core request present.
REQ-005 SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-006 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3 bits: RV32I size code; loads 000/001/010/100/101 (LB/LH/LW/LBU/LHU), stores 000/001/010 (SB/SH/SW).
REQ-008 SHALL have ports req_addr and req_wdata, input, 32 bits each: byte address and store data.
REQ-009 SHALL have ports rsp_valid (output, 1 bit), rsp_rdata (output, 32 bits) and rsp_err (output, 1 bit): one-cycle response pulse, load result and error flag.
REQ-010 SHALL have ports mem_read and mem_write, output, 1 bit each: memory strobes.
REQ-011 SHALL have ports mem_addr and mem_wdata, output, 32 bits each: word-aligned byte address and write word.
REQ-012 SHALL have port mem_rdata, input, 32 bits: memory read data, combinational in the same cycle as mem_read; memory writes on the rising clk edge while mem_write is high.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, MERGE, RESP.
REQ-014 SHALL drive req_ready high only in IDLE; the request fields are registered when req_valid && req_ready.
REQ-015 SHALL decide the transition out of IDLE on acceptance:
- illegal funct3 (011/110/111, or a store with 1xx) or out-of-range address: go to RESP with rsp_err=1.
- otherwise: go to ACCESS.
REQ-016 SHALL drive mem_addr = {addr[31:2],2'b00} in ACCESS and MERGE, and 0 otherwise.
REQ-017 SHALL handle loads in ACCESS: mem_read=1; mem_rdata lane selected by addr[1:0] (byte) or addr[1] (half); sign-extended for LB/LH, zero-extended for LBU/LHU; registered; then go to RESP.
REQ-018 SHALL handle SW in ACCESS: mem_write=1, mem_wdata=req_wdata, no mem_read; then go to RESP.
REQ-019 SHALL handle SB/SH as read-modify-write:
- ACCESS: mem_read=1, register the read word.
- MERGE: mem_write=1, mem_wdata = read word with the addressed byte/half replaced by req_wdata[7:0]/[15:0].
- then go to RESP.
REQ-020 SHALL in RESP assert rsp_valid for exactly one cycle, then return to IDLE; rsp_rdata is 0 for stores and for errors.
REQ-021 SHALL give these latencies from the acceptance edge to rsp_valid high: loads and SW 2 cycles, SB/SH 3 cycles, errors 1 cycle.
REQ-022 SHALL never assert mem_read and mem_write in the same cycle, nor either strobe outside ACCESS/MERGE.

Reset
REQ-023 SHALL, while rst_n is low, force state IDLE and all outputs 0, including req_ready; deassertion of rst_n leaves the block in IDLE with req_ready=1.
REQ-024 SHALL make reset during ACCESS/MERGE drop mem_read/mem_write immediately and lose the operation with no partial write and no response.

Configuration
REQ-025 SHALL, with LSU_MISALIGN_TRAP_EN defined, treat LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 as errors (1-cycle error response, no memory strobe).
REQ-026 SHALL, without LSU_MISALIGN_TRAP_EN, clear the misaligned low address bits and perform the access as aligned with rsp_err=0.

Structure
REQ-027 SHALL take from a shared package lsu_pkg: the funct3 constants, the FSM state typedef, and the DMEM_SIZE default.
REQ-028 SHALL place lane extraction/extension and store merge in one combinational sub-module, lsu_align.

Verification (word at 0x100 = 0x8899AABB)
REQ-029 SHALL cover LB 0x101 -> rsp_rdata 0xFFFFFFAA 2 cycles after acceptance; LBU 0x103 -> 0x00000088.
REQ-030 SHALL cover LH 0x102 -> 0xFFFF8899; LHU 0x102 -> 0x00008899.
REQ-031 SHALL cover SB 0x102 with wdata 0x12345677 -> mem_read cycle 1, mem_write cycle 2 with 0x8877AABB, rsp_valid cycle 3.
REQ-032 SHALL cover SW 0x104 0xDEADBEEF (no mem_read), then LW 0x104 -> 0xDEADBEEF.
REQ-033 SHALL cover LW 0x102: with the macro -> rsp_err=1, rsp_rdata=0, no strobes, 1-cycle latency; without it -> 0x8899AABB.
REQ-034 SHALL cover rst_n low during SH MERGE -> mem_write low immediately, word unchanged, req_ready=1 after release.
